// File: rtl/gpa_fhdo_pkg.sv
// Shared definitions for the GPA-FHDO SPI responder.
// Holds the DAC80504-style register addresses, the SYNC register reset value,
// the nominal frame lengths and the responder FSM state encoding.
package gpa_fhdo_pkg;

  localparam logic [3:0] ADDR_SYNC = 4'h2;
  localparam logic [3:0] ADDR_DAC0 = 4'h8;
  localparam logic [3:0] ADDR_DAC1 = 4'h9;
  localparam logic [3:0] ADDR_DAC2 = 4'hA;
  localparam logic [3:0] ADDR_DAC3 = 4'hB;

  localparam logic [15:0] SYNC_RST_VAL = 16'hFF00;

  localparam int unsigned DAC_FRAME_LEN = 24;
  localparam int unsigned ADC_FRAME_LEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_DECODE = 2'd2
  } state_e;

  // True for addresses that map to a real register (SYNC or DAC0..DAC3).
  function automatic logic is_reg_addr(input logic [3:0] addr);
    return (addr == ADDR_SYNC) || ((addr >= ADDR_DAC0) && (addr <= ADDR_DAC3));
  endfunction

endpackage

// File: rtl/gpa_fhdo_spi_sync.sv
// Input synchroniser and edge detector for the GPA-FHDO SPI responder.
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   spi_clk_i      raw SPI clock        spi_csn_i  raw chip select
//   spi_sdi_i      raw initiator data   sel_i      frame polarity (1: csn high = active)
//   sclk_fall_o    1-cycle pulse on a synced sclk falling edge
//   sdi_o          synced data, aligned with the synced sclk
//   fa_rise_o/fa_fall_o  frame-active edges
module gpa_fhdo_spi_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_clk_i,
  input  logic spi_csn_i,
  input  logic spi_sdi_i,
  input  logic sel_i,
  output logic sclk_fall_o,
  output logic sdi_o,
  output logic fa_rise_o,
  output logic fa_fall_o
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, csn_sync_q, sdi_sync_q;
  logic                   sclk_prev_q, csn_prev_q;
  logic                   sclk_s, csn_s, fa_now, fa_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      csn_sync_q  <= '0;
      sdi_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b0;
    end else begin
      sclk_sync_q[0] <= spi_clk_i;
      csn_sync_q[0]  <= spi_csn_i;
      sdi_sync_q[0]  <= spi_sdi_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync_q[i] <= sclk_sync_q[i-1];
        csn_sync_q[i]  <= csn_sync_q[i-1];
        sdi_sync_q[i]  <= sdi_sync_q[i-1];
      end
      sclk_prev_q <= sclk_s;
      csn_prev_q  <= csn_s;
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s  = csn_sync_q[SYNC_STAGES-1];
  assign sdi_o  = sdi_sync_q[SYNC_STAGES-1];

  assign sclk_fall_o = sclk_prev_q & ~sclk_s;

  // Both samples use the same polarity, so a change of sel_i alone never
  // looks like a frame edge.
  assign fa_now    = ~(csn_s ^ sel_i);
  assign fa_prev   = ~(csn_prev_q ^ sel_i);
  assign fa_rise_o = fa_now & ~fa_prev;
  assign fa_fall_o = ~fa_now & fa_prev;

endmodule

// File: rtl/gpa_fhdo_spi_responder.sv
// GPA-FHDO board-side SPI responder (simulation / loopback model).
// Receives 24-bit DAC frames (csn low active) and 32-bit ADC frames (csn high
// active), decodes DAC register writes and returns a latched ADC word.
// Optional feature macro: GPA_FHDO_RESP_READBACK_EN (DAC register readback).
// Ports:
//   clk, rst_n                  system clock, asynchronous active-low reset
//   spi_clk_i/csn_i/sdi_i       SPI from initiator;  spi_sdo_o  data return
//   adc_sel_i                   frame type select (latched at frame start)
//   adc_value_i                 word returned in ADC frames
//   dac_ch0_o..dac_ch3_o        DAC channel registers
//   sync_reg_o                  SYNC register mirror
//   dac_update_o, adc_done_o, frame_err_o   1-cycle status pulses
//   adc_cmd_o                   first 16 bits of the last ADC frame
module gpa_fhdo_spi_responder
  import gpa_fhdo_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned DAC_FRAME_BITS = DAC_FRAME_LEN,
  parameter int unsigned ADC_FRAME_BITS = ADC_FRAME_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk_i,
  input  logic              spi_csn_i,
  input  logic              spi_sdi_i,
  output logic              spi_sdo_o,
  input  logic              adc_sel_i,
  input  logic [DATA_W-1:0] adc_value_i,
  output logic [DATA_W-1:0] dac_ch0_o,
  output logic [DATA_W-1:0] dac_ch1_o,
  output logic [DATA_W-1:0] dac_ch2_o,
  output logic [DATA_W-1:0] dac_ch3_o,
  output logic [DATA_W-1:0] sync_reg_o,
  output logic              dac_update_o,
  output logic [DATA_W-1:0] adc_cmd_o,
  output logic              adc_done_o,
  output logic              frame_err_o
);

  localparam int unsigned CNT_W = 6;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [ADC_FRAME_BITS-1:0] sr_q, sr_d;
  logic [DATA_W-1:0]         adc_word_q, adc_word_d;
  logic                      sel_q, sel_d;
  logic [DATA_W-1:0]         dac_q [4];
  logic [DATA_W-1:0]         dac_d [4];
  logic [DATA_W-1:0]         sync_q, sync_d, adc_cmd_q, adc_cmd_d;
  logic                      upd_q, upd_d, done_q, done_d, err_q, err_d;

  logic                      sel_eff, sclk_fall, sdi_s, fa_rise, fa_fall;
  logic                      fr_rw;
  logic [3:0]                fr_addr;
  logic [DATA_W-1:0]         fr_data;
  logic                      sdo;
  logic [DATA_W-1:0]         adc_shift;

`ifdef GPA_FHDO_RESP_READBACK_EN
  logic                      rb_armed_q, rb_armed_d, rb_active_q, rb_active_d;
  logic [3:0]                rb_addr_q, rb_addr_d;
  logic [DAC_FRAME_BITS-1:0] rb_word_q, rb_word_d, rb_shift;
  logic [DATA_W-1:0]         rb_read;
`endif

  // Outside a frame the live select decides polarity; inside, the latched one.
  assign sel_eff = (state_q == ST_IDLE) ? adc_sel_i : sel_q;

  gpa_fhdo_spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_clk_i   (spi_clk_i),
    .spi_csn_i   (spi_csn_i),
    .spi_sdi_i   (spi_sdi_i),
    .sel_i       (sel_eff),
    .sclk_fall_o (sclk_fall),
    .sdi_o       (sdi_s),
    .fa_rise_o   (fa_rise),
    .fa_fall_o   (fa_fall)
  );

  assign fr_rw   = sr_q[DAC_FRAME_BITS-1];
  assign fr_addr = sr_q[DATA_W +: 4];
  assign fr_data = sr_q[DATA_W-1:0];

`ifdef GPA_FHDO_RESP_READBACK_EN
  always_comb begin
    rb_read = '0;
    case (rb_addr_q)
      ADDR_SYNC: rb_read = sync_q;
      ADDR_DAC0: rb_read = dac_q[0];
      ADDR_DAC1: rb_read = dac_q[1];
      ADDR_DAC2: rb_read = dac_q[2];
      ADDR_DAC3: rb_read = dac_q[3];
      default:   rb_read = '0;
    endcase
  end
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    adc_word_d = adc_word_q;
    sel_d      = sel_q;
    dac_d      = dac_q;
    sync_d     = sync_q;
    adc_cmd_d  = adc_cmd_q;
    upd_d      = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
`ifdef GPA_FHDO_RESP_READBACK_EN
    rb_armed_d  = rb_armed_q;
    rb_active_d = rb_active_q;
    rb_addr_d   = rb_addr_q;
    rb_word_d   = rb_word_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (fa_rise) begin
          state_d    = ST_SHIFT;
          bit_cnt_d  = '0;
          sr_d       = '0;
          adc_word_d = adc_value_i;
          sel_d      = adc_sel_i;
`ifdef GPA_FHDO_RESP_READBACK_EN
          // An armed readback is consumed by the next DAC frame, whatever its length.
          if (!adc_sel_i) begin
            rb_active_d = rb_armed_q;
            rb_armed_d  = 1'b0;
            rb_word_d   = DAC_FRAME_BITS'(rb_read);
          end
`endif
        end
      end
      ST_SHIFT: begin
        if (sclk_fall) begin
          sr_d = {sr_q[ADC_FRAME_BITS-2:0], sdi_s};
          if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 1'b1;
        end
        if (fa_fall) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
`ifdef GPA_FHDO_RESP_READBACK_EN
        rb_active_d = 1'b0;
`endif
        if (!sel_q && (bit_cnt_q == CNT_W'(DAC_FRAME_BITS))) begin
          if (!fr_rw) begin
            case (fr_addr)
              ADDR_SYNC: begin sync_d   = fr_data; upd_d = 1'b1; end
              ADDR_DAC0: begin dac_d[0] = fr_data; upd_d = 1'b1; end
              ADDR_DAC1: begin dac_d[1] = fr_data; upd_d = 1'b1; end
              ADDR_DAC2: begin dac_d[2] = fr_data; upd_d = 1'b1; end
              ADDR_DAC3: begin dac_d[3] = fr_data; upd_d = 1'b1; end
              default: ;
            endcase
          end
`ifdef GPA_FHDO_RESP_READBACK_EN
          else if (is_reg_addr(fr_addr)) begin
            rb_armed_d = 1'b1;
            rb_addr_d  = fr_addr;
          end
`endif
        end else if (sel_q && (bit_cnt_q == CNT_W'(ADC_FRAME_BITS))) begin
          adc_cmd_d = sr_q[ADC_FRAME_BITS-1 -: DATA_W];
          done_d    = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Return path: the ADC word starts after falling edge #(ADC-DATA_W) and
  // advances one bit per later falling edge.
  always_comb begin
    sdo       = 1'b0;
    adc_shift = adc_word_q << (bit_cnt_q - CNT_W'(ADC_FRAME_BITS - DATA_W));
`ifdef GPA_FHDO_RESP_READBACK_EN
    rb_shift  = rb_word_q << bit_cnt_q;
`endif
    if (state_q == ST_SHIFT) begin
      if (sel_q) begin
        if ((bit_cnt_q >= CNT_W'(ADC_FRAME_BITS - DATA_W)) &&
            (bit_cnt_q <  CNT_W'(ADC_FRAME_BITS)))
          sdo = adc_shift[DATA_W-1];
      end
`ifdef GPA_FHDO_RESP_READBACK_EN
      else if (rb_active_q && (bit_cnt_q < CNT_W'(DAC_FRAME_BITS))) begin
        sdo = rb_shift[DAC_FRAME_BITS-1];
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      adc_word_q <= '0;
      sel_q      <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) dac_q[i] <= '0;
      sync_q     <= DATA_W'(SYNC_RST_VAL);
      adc_cmd_q  <= '0;
      upd_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef GPA_FHDO_RESP_READBACK_EN
      rb_armed_q  <= 1'b0;
      rb_active_q <= 1'b0;
      rb_addr_q   <= '0;
      rb_word_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      adc_word_q <= adc_word_d;
      sel_q      <= sel_d;
      dac_q      <= dac_d;
      sync_q     <= sync_d;
      adc_cmd_q  <= adc_cmd_d;
      upd_q      <= upd_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef GPA_FHDO_RESP_READBACK_EN
      rb_armed_q  <= rb_armed_d;
      rb_active_q <= rb_active_d;
      rb_addr_q   <= rb_addr_d;
      rb_word_q   <= rb_word_d;
`endif
    end
  end

  assign spi_sdo_o    = sdo;
  assign dac_ch0_o    = dac_q[0];
  assign dac_ch1_o    = dac_q[1];
  assign dac_ch2_o    = dac_q[2];
  assign dac_ch3_o    = dac_q[3];
  assign sync_reg_o   = sync_q;
  assign adc_cmd_o    = adc_cmd_q;
  assign dac_update_o = upd_q;
  assign adc_done_o   = done_q;
  assign frame_err_o  = err_q;

endmodule

// File: tb/tb_gpa_fhdo_spi_responder.sv
// Self-checking bench for gpa_fhdo_spi_responder: drives initiator frames,
// keeps a frame-level reference model and compares every quiet cycle.
module tb_gpa_fhdo_spi_responder;

`ifdef GPA_FHDO_RESP_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_clk_i, spi_csn_i, spi_sdi_i, spi_sdo_o, adc_sel_i;
  logic [15:0] adc_value_i;
  logic [15:0] dac_ch0_o, dac_ch1_o, dac_ch2_o, dac_ch3_o, sync_reg_o, adc_cmd_o;
  logic        dac_update_o, adc_done_o, frame_err_o;

  always #5 clk = ~clk;

  gpa_fhdo_spi_responder #(
    .SYNC_STAGES(2), .DATA_W(16), .DAC_FRAME_BITS(24), .ADC_FRAME_BITS(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_clk_i(spi_clk_i), .spi_csn_i(spi_csn_i), .spi_sdi_i(spi_sdi_i),
    .spi_sdo_o(spi_sdo_o), .adc_sel_i(adc_sel_i), .adc_value_i(adc_value_i),
    .dac_ch0_o(dac_ch0_o), .dac_ch1_o(dac_ch1_o), .dac_ch2_o(dac_ch2_o),
    .dac_ch3_o(dac_ch3_o), .sync_reg_o(sync_reg_o), .dac_update_o(dac_update_o),
    .adc_cmd_o(adc_cmd_o), .adc_done_o(adc_done_o), .frame_err_o(frame_err_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_dac [4];
  logic [15:0] m_sync, m_cmd;
  bit          m_armed;
  logic [3:0]  m_rb_addr;
  bit          cur_sel, cur_rb_active;
  logic [15:0] cur_word;
  logic [23:0] cur_rb_word;

  int n_upd = 0, n_done = 0, n_err = 0;
  bit quiet = 1'b0, in_frame = 1'b0;

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [3:0] a);
    case (a)
      4'h2:    return m_sync;
      4'h8:    return m_dac[0];
      4'h9:    return m_dac[1];
      4'hA:    return m_dac[2];
      4'hB:    return m_dac[3];
      default: return 16'h0000;
    endcase
  endfunction

  // Value the initiator must see on sdo at rising edge k (1-based).
  function automatic logic exp_sdo(input int k);
    if (cur_sel) return (k >= 17 && k <= 32) ? cur_word[32-k] : 1'b0;
    return (RB_EN && cur_rb_active && k <= 24) ? cur_rb_word[24-k] : 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_dac[i] = 16'h0000;
    m_sync = 16'hFF00;
    m_cmd = 16'h0000;
    m_armed = 1'b0;
    m_rb_addr = 4'h0;
    cur_rb_active = 1'b0;
  endtask

  task automatic model_start(input bit sel, input logic [15:0] word);
    cur_sel = sel;
    cur_word = word;
    cur_rb_active = 1'b0;
    if (!sel) begin
      cur_rb_active = m_armed;
      cur_rb_word = {8'h00, model_read(m_rb_addr)};
      m_armed = 1'b0;
    end
  endtask

  task automatic model_end(input logic [39:0] p, input int n, output int eu, output int ed, output int ee);
    logic [3:0] a;
    eu = 0; ed = 0; ee = 0;
    a = p[19:16];
    if (!cur_sel && n == 24) begin
      if (!p[23]) begin
        if (a == 4'h2) begin m_sync = p[15:0]; eu = 1; end
        else if (a >= 4'h8 && a <= 4'hB) begin m_dac[a-4'h8] = p[15:0]; eu = 1; end
      end else if (a == 4'h2 || (a >= 4'h8 && a <= 4'hB)) begin
        m_armed = 1'b1;
        m_rb_addr = a;
      end
    end else if (cur_sel && n == 32) begin
      m_cmd = p[31:16];
      ed = 1;
    end else begin
      ee = 1;
    end
  endtask

  always @(negedge clk) begin
    if (dac_update_o === 1'b1) n_upd++;
    if (adc_done_o === 1'b1) n_done++;
    if (frame_err_o === 1'b1) n_err++;
  end

  // Per-cycle compare against the model while no decode is pending.
  always @(negedge clk) begin
    if (quiet) begin
      chk("dac0", dac_ch0_o, m_dac[0]);
      chk("dac1", dac_ch1_o, m_dac[1]);
      chk("dac2", dac_ch2_o, m_dac[2]);
      chk("dac3", dac_ch3_o, m_dac[3]);
      chk("sync", sync_reg_o, m_sync);
      chk("adc_cmd", adc_cmd_o, m_cmd);
      chk("upd_idle", dac_update_o, 1'b0);
      chk("done_idle", adc_done_o, 1'b0);
      chk("err_idle", frame_err_o, 1'b0);
      if (!in_frame) chk("sdo_idle", spi_sdo_o, 1'b0);
    end
  end

  task automatic do_frame(input bit sel, input logic [39:0] payload, input int n,
                          input logic [15:0] word, input bit tog, input int rst_at,
                          output logic [39:0] cap);
    int bu, bd, be, eu, ed, ee;
    adc_sel_i = sel;
    repeat (2) @(negedge clk);
    spi_csn_i = ~sel;
    adc_value_i = word;
    repeat (6) @(negedge clk);
    bu = n_upd; bd = n_done; be = n_err;
    in_frame = 1'b1;
    model_start(sel, word);
    spi_csn_i = sel;
    repeat (6) @(negedge clk);
    adc_value_i = 16'($urandom);
    if (tog) adc_sel_i = ~sel;
    cap = '0;
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        quiet = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("sdo_in_reset", spi_sdo_o, 1'b0);
        model_reset();
        spi_clk_i = 1'b0;
        spi_csn_i = ~sel;
        adc_sel_i = sel;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_upd_cnt", n_upd - bu, 0);
        chk("rst_done_cnt", n_done - bd, 0);
        chk("rst_err_cnt", n_err - be, 0);
        in_frame = 1'b0;
        quiet = 1'b1;
        return;
      end
      spi_sdi_i = payload[n-1-i];
      chk("sdo_bit", spi_sdo_o, exp_sdo(i + 1));
      cap = {cap[38:0], spi_sdo_o};
      spi_clk_i = 1'b1;
      repeat (4) @(negedge clk);
      spi_clk_i = 1'b0;
      repeat (4) @(negedge clk);
    end
    quiet = 1'b0;
    spi_csn_i = ~sel;
    model_end(payload, n, eu, ed, ee);
    adc_sel_i = sel;
    repeat (10) @(negedge clk);
    chk("upd_cnt", n_upd - bu, eu);
    chk("done_cnt", n_done - bd, ed);
    chk("err_cnt", n_err - be, ee);
    in_frame = 1'b0;
    quiet = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [39:0] cap, p;
    int u0, n, r;
    bit sel;
    logic [3:0] a;

    rst_n = 1'b0;
    spi_clk_i = 1'b0; spi_csn_i = 1'b1; spi_sdi_i = 1'b0;
    adc_sel_i = 1'b0; adc_value_i = 16'h0000;
    cur_sel = 1'b0; cur_word = '0; cur_rb_word = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_dac0", dac_ch0_o, 16'h0000);
    chk("rst_dac1", dac_ch1_o, 16'h0000);
    chk("rst_dac2", dac_ch2_o, 16'h0000);
    chk("rst_dac3", dac_ch3_o, 16'h0000);
    chk("rst_sync", sync_reg_o, 16'hFF00);
    chk("rst_cmd", adc_cmd_o, 16'h0000);
    chk("rst_sdo", spi_sdo_o, 1'b0);
    chk("rst_pulses", {dac_update_o, adc_done_o, frame_err_o}, 3'b000);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    quiet = 1'b1;

    u0 = n_upd;
    do_frame(1'b0, 40'h09_1234, 24, 16'h0000, 1'b0, -1, cap);
    chk("lit_dac1", dac_ch1_o, 16'h1234);
    chk("lit_dac0", dac_ch0_o, 16'h0000);
    chk("lit_upd_once", n_upd - u0, 1);

    do_frame(1'b1, 40'hD000_0000, 32, 16'hA5C3, 1'b0, -1, cap);
    chk("lit_adc_cap", cap[15:0], 16'hA5C3);
    chk("lit_adc_cmd", adc_cmd_o, 16'hD000);

    u0 = n_err;
    do_frame(1'b0, 40'h0000_1234, 13, 16'h0000, 1'b0, -1, cap);
    chk("lit_err_once", n_err - u0, 1);
    chk("lit_dac1_kept", dac_ch1_o, 16'h1234);
    do_frame(1'b0, 40'h0B_FFFF, 24, 16'h0000, 1'b0, -1, cap);
    chk("lit_dac3", dac_ch3_o, 16'hFFFF);

    do_frame(1'b1, 40'h1234_5678, 32, 16'hBEEF, 1'b0, 10, cap);
    chk("lit_dac3_cleared", dac_ch3_o, 16'h0000);
    do_frame(1'b1, 40'hCAFE_0000, 32, 16'hFFFF, 1'b0, 20, cap);
    do_frame(1'b1, 40'h8001_0000, 32, 16'h0F0F, 1'b1, -1, cap);
    chk("lit_adc_cap2", cap[15:0], 16'h0F0F);
    chk("lit_adc_cmd2", adc_cmd_o, 16'h8001);

    do_frame(1'b0, 40'h08_BEEF, 24, 16'h0000, 1'b0, -1, cap);
    do_frame(1'b0, 40'h88_0000, 24, 16'h0000, 1'b0, -1, cap);
    do_frame(1'b0, 40'h00_0000, 24, 16'h0000, 1'b0, -1, cap);
`ifdef GPA_FHDO_RESP_READBACK_EN
    chk("lit_readback", cap[23:0], 24'h00BEEF);
`else
    chk("lit_no_readback", cap[23:0], 24'h000000);
`endif

    for (int f = 0; f < 40; f++) begin
      sel = 1'($urandom_range(0, 1));
      if (sel) begin
        p = {8'h00, 32'($urandom)};
        n = 32;
      end else begin
        r = $urandom_range(0, 7);
        if (r == 0) a = 4'h2;
        else if (r <= 4) a = 4'h8 + 4'(r - 1);
        else a = 4'($urandom);
        p = {16'h0000, ($urandom_range(0, 3) == 0), 3'($urandom), a, 16'($urandom)};
        n = 24;
      end
      if ($urandom_range(0, 9) == 0) n = $urandom_range(0, 40);
      do_frame(sel, p, n, 16'($urandom), ($urandom_range(0, 3) == 0), -1, cap);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
